// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx: MSB-first serial-to-parallel deserializer with a small
// first-word-fall-through output FIFO and a sticky overflow flag.
//
// Ports:
//   clk, reset        single clock (posedge), asynchronous active-high reset
//   start             frame alignment; discards the partial word
//   bit_valid         serial_in is sampled on this edge
//   serial_in         serial data, MSB first
//   out_ready         consumer accepts out_data this cycle
//   clear_overflow    clears the sticky overflow flag
//   out_data          head-of-FIFO word (registered storage, FWFT)
//   out_valid         FIFO not empty
//   fifo_count        words queued, 0..DEPTH
//   bit_count         bits held in the current partial word, 0..WIDTH-1
//   overflow          sticky: a completed word was dropped on a full FIFO
//
// Latency: a word whose last bit is accepted on edge N is visible in cycle N+1.
// Backpressure: out_valid/out_data never depend combinationally on out_ready;
// a word completing into a full FIFO with no same-cycle pop is dropped.
//
// Integration: the upstream serializer registers serial_out, so bit_valid
// must be the upstream shift enable (enable && !done) delayed by one flop.
//
// Parameter constraints: WIDTH >= 2, DEPTH a power of 2 and >= 2. Pointers
// rely on natural modulo-DEPTH wrap, which only holds for a power of 2.

module serial_to_parallel_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     bit_valid,
  input  logic                     serial_in,
  input  logic                     out_ready,
  input  logic                     clear_overflow,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [$clog2(WIDTH):0]   bit_count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);     // pointer width
  localparam int CW = $clog2(DEPTH) + 1; // occupancy counter width
  localparam int BW = $clog2(WIDTH) + 1; // bit counter width

  // ---------------------------------------------------------------------------
  // Deserializer state
  // ---------------------------------------------------------------------------
  // Only the low WIDTH-1 bits of the shift register are kept: the oldest bit
  // would be shifted out on the very edge that completes a word, so it is
  // never needed. The completed word is formed from these bits plus the bit
  // arriving on the completing edge.
  logic [WIDTH-2:0] partial_q, partial_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;

  logic [WIDTH-1:0] word_next;
  logic             last_bit;
  logic             push;

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             fifo_full;
  logic             fifo_nempty;
  logic             pop;
  logic             push_ok;
  logic             drop;

  // ---------------------------------------------------------------------------
  // Deserializer next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    word_next = {partial_q, serial_in};
    last_bit  = bit_valid && (bit_cnt_q == BW'(WIDTH - 1));
    // start always wins over a completing bit: the word it would have
    // finished belongs to the misaligned frame being discarded.
    push      = last_bit && !start;

    partial_d = partial_q;
    bit_cnt_d = bit_cnt_q;

    // Stale bits left in partial_q after a start are harmless: they are
    // shifted out before the realigned word can complete.
    if (bit_valid) begin
      partial_d = word_next[WIDTH-2:0];
    end

    if (start) begin
      // With bit_valid the sampled bit is the MSB of the new word.
      bit_cnt_d = bit_valid ? BW'(1) : '0;
    end else if (bit_valid) begin
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      partial_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      partial_q <= partial_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_full   = (count_q == CW'(DEPTH));
    fifo_nempty = (count_q != '0);
    pop         = fifo_nempty && out_ready;
    // A same-cycle pop frees the head slot, so a push into a full FIFO is
    // still accepted; the write lands in the slot wr_ptr already points to,
    // which equals rd_ptr when full and is being vacated this edge.
    push_ok     = push && (!fifo_full || pop);
    drop        = push && fifo_full && !pop;

    rd_ptr_d = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;

    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Set has priority over clear so a drop coinciding with a clear is
    // never lost.
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_overflow) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is reset so out_data reads 0 until the first word is written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= word_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registered state only
  // ---------------------------------------------------------------------------
  assign out_data   = mem_q[rd_ptr_q];
  assign out_valid  = fifo_nempty;
  assign fifo_count = count_q;
  assign bit_count  = bit_cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Testbench for serial_to_parallel_rx (WIDTH=8, DEPTH=4).
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point, i.e. well away from the active edge.

module tb_serial_to_parallel_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       serial_in = 1'b0;
  logic       out_ready = 1'b0;
  logic       clear_overflow = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] fifo_count;
  logic [3:0] bit_count;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  serial_to_parallel_rx #(.WIDTH(8), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .bit_valid      (bit_valid),
    .serial_in      (serial_in),
    .out_ready      (out_ready),
    .clear_overflow (clear_overflow),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .fifo_count     (fifo_count),
    .bit_count      (bit_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       st;
    logic       bv;
    logic       si;
    logic       rdy;
    logic       clr;
    logic       vld;
    logic [7:0] data;
    logic [2:0] cnt;
    logic [3:0] bc;
    logic       ovf;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(input logic st, input logic bv, input logic si,
                              input logic rdy, input logic clr, input logic vld,
                              input logic [7:0] d, input logic [2:0] c,
                              input logic [3:0] bc, input logic ovf);
    vec_t v;
    v.st = st; v.bv = bv; v.si = si; v.rdy = rdy; v.clr = clr;
    v.vld = vld; v.data = d; v.cnt = c; v.bc = bc; v.ovf = ovf;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, settle just after it.
  task automatic step(input logic st, input logic bv, input logic si,
                      input logic rdy, input logic clr);
    start = st; bit_valid = bv; serial_in = si; out_ready = rdy; clear_overflow = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy, input logic clr);
    for (int b = 7; b >= 0; b--) step(1'b0, 1'b1, w[b], rdy, clr);
  endtask

  // Expect a given head word, then pop it.
  task automatic drain_check(input string nm, input logic [7:0] exp);
    check({nm, "_vld"}, 32'(out_valid), 32'd1);
    check({nm, "_dat"}, 32'(out_data), 32'(exp));
    idle(1'b1);
  endtask

  task automatic do_reset();
    start = 0; bit_valid = 0; serial_in = 0; out_ready = 0; clear_overflow = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] words [3];
    logic [7:0] got [$];

    // ---------------- table: single word A5 ----------------
    pat = 8'hA5;
    tbl[0] = mk(1, 0, 0, 0, 0, 0, 8'h00, 3'd0, 4'd0, 0);
    for (int i = 0; i < 8; i++) begin
      tbl[i+1] = mk(0, 1, pat[7-i], 0, 0, (i == 7), (i == 7) ? 8'hA5 : 8'h00,
                    (i == 7) ? 3'd1 : 3'd0, (i == 7) ? 4'd0 : 4'(i + 1), 0);
    end
    // Pop leaves the FIFO empty; next slot was never written so reads 0.
    tbl[9] = mk(0, 0, 0, 1, 0, 0, 8'h00, 3'd0, 4'd0, 0);

    do_reset();
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_dat", 32'(out_data), 32'd0);
    check("rst_cnt", 32'(fifo_count), 32'd0);
    check("rst_bc", 32'(bit_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].st, tbl[i].bv, tbl[i].si, tbl[i].rdy, tbl[i].clr);
      check($sformatf("t1_vld[%0d]", i), 32'(out_valid), 32'(tbl[i].vld));
      check($sformatf("t1_dat[%0d]", i), 32'(out_data), 32'(tbl[i].data));
      check($sformatf("t1_cnt[%0d]", i), 32'(fifo_count), 32'(tbl[i].cnt));
      check($sformatf("t1_bc[%0d]", i), 32'(bit_count), 32'(tbl[i].bc));
      check($sformatf("t1_ovf[%0d]", i), 32'(overflow), 32'(tbl[i].ovf));
    end

    // ---------------- back-to-back with out_ready=1 ----------------
    do_reset();
    words[0] = 8'h3C; words[1] = 8'hC3; words[2] = 8'hFF;
    for (int w = 0; w < 3; w++) begin
      for (int b = 7; b >= 0; b--) begin
        step(1'b0, 1'b1, words[w][b], 1'b1, 1'b0);
        if (out_valid) got.push_back(out_data);
      end
    end
    idle(1'b1);
    check("b2b_npulses", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) check($sformatf("b2b_word[%0d]", i), 32'(got[i]), 32'(words[i]));
    end
    check("b2b_vld_end", 32'(out_valid), 32'd0);
    check("b2b_ovf", 32'(overflow), 32'd0);

    // ---------------- overflow, set-beats-clear, drain, clear ----------------
    do_reset();
    for (int w = 1; w <= 4; w++) send_word(8'(w), 1'b0, 1'b0);
    check("ovf_cnt4", 32'(fifo_count), 32'd4);
    check("ovf_pre", 32'(overflow), 32'd0);
    send_word(8'h05, 1'b0, 1'b0);
    check("ovf_cnt_after5", 32'(fifo_count), 32'd4);
    check("ovf_set", 32'(overflow), 32'd1);
    // Clear held through word 06; its drop on the last edge must win.
    send_word(8'h06, 1'b0, 1'b1);
    check("ovf_set_wins", 32'(overflow), 32'd1);
    check("ovf_cnt_after6", 32'(fifo_count), 32'd4);
    for (int w = 1; w <= 4; w++) drain_check($sformatf("ovf_drain%0d", w), 8'(w));
    check("ovf_empty", 32'(out_valid), 32'd0);
    check("ovf_still_set", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_cleared", 32'(overflow), 32'd0);

    // ---------------- full FIFO, push and pop on the same edge ----------------
    do_reset();
    for (int w = 2; w <= 5; w++) send_word(8'(w), 1'b0, 1'b0);
    pat = 8'h06;
    for (int b = 7; b >= 1; b--) step(1'b0, 1'b1, pat[b], 1'b0, 1'b0);
    check("fpp_head", 32'(out_data), 32'h02);
    step(1'b0, 1'b1, pat[0], 1'b1, 1'b0);
    check("fpp_cnt", 32'(fifo_count), 32'd4);
    check("fpp_ovf", 32'(overflow), 32'd0);
    for (int w = 3; w <= 6; w++) drain_check($sformatf("fpp_drain%0d", w), 8'(w));
    check("fpp_empty", 32'(out_valid), 32'd0);

    // ---------------- realignment ----------------
    do_reset();
    pat = 8'b11011000;
    for (int b = 7; b >= 3; b--) step(1'b0, 1'b1, pat[b], 1'b0, 1'b0);
    check("ral_bc5", 32'(bit_count), 32'd5);
    pat = 8'h81;
    step(1'b1, 1'b1, pat[7], 1'b0, 1'b0);
    check("ral_bc1", 32'(bit_count), 32'd1);
    check("ral_nopush", 32'(fifo_count), 32'd0);
    for (int b = 6; b >= 0; b--) step(1'b0, 1'b1, pat[b], 1'b0, 1'b0);
    check("ral_cnt", 32'(fifo_count), 32'd1);
    check("ral_dat", 32'(out_data), 32'h81);
    // start on the edge that would complete a word: no push, new MSB taken.
    for (int b = 0; b < 7; b++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("ral_bc7", 32'(bit_count), 32'd7);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("ral_start_wins_cnt", 32'(fifo_count), 32'd1);
    check("ral_start_wins_bc", 32'(bit_count), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ral_start_only_bc", 32'(bit_count), 32'd0);
    drain_check("ral_drain", 8'h81);
    check("ral_empty", 32'(out_valid), 32'd0);

    // ---------------- asynchronous reset mid-word ----------------
    do_reset();
    send_word(8'hAA, 1'b0, 1'b0);
    send_word(8'h55, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("ar_pre_cnt", 32'(fifo_count), 32'd2);
    check("ar_pre_bc", 32'(bit_count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("ar_vld", 32'(out_valid), 32'd0);
    check("ar_dat", 32'(out_data), 32'd0);
    check("ar_cnt", 32'(fifo_count), 32'd0);
    check("ar_bc", 32'(bit_count), 32'd0);
    check("ar_ovf", 32'(overflow), 32'd0);
    #2;
    reset = 1'b0;
    send_word(8'h96, 1'b0, 1'b0);
    check("ar_next_vld", 32'(out_valid), 32'd1);
    check("ar_next_dat", 32'(out_data), 32'h96);
    check("ar_next_cnt", 32'(fifo_count), 32'd1);
    check("ar_next_bc", 32'(bit_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
